// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller for the async FIFO: round-robin arbitration of two requesters,
// a registered RAM write port, Gray pointer export and full/almost_full/level flags.
module fifo_wr_arb_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  grant_id
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rq_sync1;
    logic [PW-1:0] rq_sync2;
    logic          prio;        // 0: requester 0 wins a tie, 1: requester 1 wins
    logic          xfer;
    logic          sel;
    logic [PW-1:0] wr_bin_next;
    logic [PW-1:0] wr_gray_next;
    logic [PW-1:0] level_next;
    logic [PW-1:0] free_next;
    logic          full_next;
    logic          af_next;

    // Handshake: a word moves on a rising edge where reqX_valid && reqX_ready.
    // Ready is driven by arbitration only (reset, full, the other requester's
    // valid and the round-robin priority), never by the requester's own valid.
    always_comb begin
        req0_ready = wr_rst_n && !full && (!req1_valid || !prio);
        req1_ready = wr_rst_n && !full && (!req0_valid ||  prio);
    end

    always_comb begin
        sel          = req1_valid && req1_ready;
        xfer         = (req0_valid && req0_ready) || sel;
        wr_bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, xfer};
        wr_gray_next = bin2gray(wr_bin_next);
        full_next    = (wr_gray_next == {~rq_sync2[PW-1:PW-2], rq_sync2[PW-3:0]});
        level_next   = wr_bin_next - gray2bin(rq_sync2);
        free_next    = DEPTH - level_next;
        af_next      = (free_next <= PW'(AF_MARGIN));
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin      <= '0;
            rq_sync1    <= '0;
            rq_sync2    <= '0;
            prio        <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            grant_id    <= 1'b0;
        end else begin
            rq_sync1    <= rd_ptr_gray;
            rq_sync2    <= rq_sync1;
            wr_bin      <= wr_bin_next;
            // Lags wr_bin by one edge so it publishes only data the RAM has written.
            wr_ptr_gray <= bin2gray(wr_bin);
            full        <= full_next;
            almost_full <= af_next;
            wr_level    <= level_next;
            ram_wr_en   <= xfer;
            if (xfer) begin
                ram_wr_addr <= wr_bin[ADDR_WIDTH-1:0];
                ram_wr_data <= sel ? req1_data : req0_data;
                grant_id    <= sel;
                prio        <= ~sel;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed bench for fifo_wr_arb_ctrl: reset, fill to full, round-robin, full release,
// pointer wrap with a reader model over a RAM model, and reset during a transfer.
module tb_fifo_wr_arb_ctrl;

    logic       wr_clk;
    logic       wr_rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [4:0] rd_ptr_gray;
    logic       ram_wr_en;
    logic [3:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       grant_id;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];
    logic [7:0] exp_q[$];

    fifo_wr_arb_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_ptr_gray(rd_ptr_gray),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .grant_id(grant_id)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // RAM model: the write port of the dual-port RAM.
    always @(posedge wr_clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic do_reset();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_data   = 8'h00;
        req1_data   = 8'h00;
        rd_ptr_gray = 5'd0;
        wr_rst_n    = 1'b0;
        repeat (2) @(negedge wr_clk);
        wr_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wr_rst_n    = 1'b0;
        rd_ptr_gray = 5'd0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_data   = 8'h11;
        req1_data   = 8'h22;
        repeat (2) @(negedge wr_clk);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
        end
        total++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, wr_ptr_gray, full, almost_full, wr_level, grant_id} !== '0) begin
            bad++; $display("FAIL reset_outputs en=%b addr=%h data=%h gray=%h full=%b af=%b lvl=%0d gnt=%b exp all 0",
                            ram_wr_en, ram_wr_addr, ram_wr_data, wr_ptr_gray, full, almost_full, wr_level, grant_id);
        end
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL reset_release_prio got=%b exp=10", {req0_ready, req1_ready});
        end
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, grant_id, wr_level} !== {1'b1, 4'd0, 8'h11, 1'b0, 5'd1}) begin
            bad++; $display("FAIL reset_first_xfer en=%b addr=%0d data=%h gnt=%b lvl=%0d exp 1/0/11/0/1",
                            ram_wr_en, ram_wr_addr, ram_wr_data, grant_id, wr_level);
        end
        @(negedge wr_clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, ram_wr_data, wr_ptr_gray} !== {1'b0, 8'h11, 5'd1}) begin
            bad++; $display("FAIL reset_idle_hold en=%b data=%h gray=%h exp 0/11/01", ram_wr_en, ram_wr_data, wr_ptr_gray);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge wr_clk);
            req0_valid = 1'b1;
            req0_data  = 8'(i);
            #1;
            total++;
            if (req0_ready !== 1'b1) begin
                bad++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, req0_ready);
            end
            @(posedge wr_clk); #1;
            total++;
            if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 4'(i), 8'(i)}) begin
                bad++; $display("FAIL fill_write i=%0d en=%b addr=%0d data=%h exp 1/%0d/%h", i, ram_wr_en, ram_wr_addr, ram_wr_data, i, i);
            end
            total++;
            if ({wr_level, almost_full, full} !== {5'(i + 1), (i + 1) >= 14, i == 15}) begin
                bad++; $display("FAIL fill_flags i=%0d lvl=%0d af=%b full=%b exp %0d/%b/%b", i, wr_level, almost_full, full,
                                i + 1, (i + 1) >= 14, i == 15);
            end
        end
        @(negedge wr_clk);
        req0_data = 8'h10;
        #1;
        total++;
        if (req0_ready !== 1'b0) begin
            bad++; $display("FAIL fill_stall got=%b exp=0", req0_ready);
        end
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, full, wr_level, wr_ptr_gray} !== {1'b0, 1'b1, 5'd16, 5'b11000}) begin
            bad++; $display("FAIL fill_full_state en=%b full=%b lvl=%0d gray=%b exp 0/1/16/11000", ram_wr_en, full, wr_level, wr_ptr_gray);
        end
    endtask

    task automatic test_full_release();
        @(negedge wr_clk);
        req0_valid  = 1'b0;
        rd_ptr_gray = 5'd1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge wr_clk); #1;
            total++;
            if (full !== (e < 3)) begin
                bad++; $display("FAIL release_full edge=%0d got=%b exp=%b", e, full, e < 3);
            end
        end
        total++;
        if ({wr_level, almost_full} !== {5'd15, 1'b1}) begin
            bad++; $display("FAIL release_level lvl=%0d af=%b exp 15/1", wr_level, almost_full);
        end
        @(negedge wr_clk);
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL release_ready got=%b exp=1", req0_ready);
        end
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, full, wr_level} !== {1'b1, 4'd0, 8'h5A, 1'b1, 5'd16}) begin
            bad++; $display("FAIL release_refill en=%b addr=%0d data=%h full=%b lvl=%0d exp 1/0/5a/1/16",
                            ram_wr_en, ram_wr_addr, ram_wr_data, full, wr_level);
        end
        @(negedge wr_clk);
        req0_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic       g;
            logic [7:0] d;
            g = k[0];
            d = g ? (8'hB0 | 8'(k)) : (8'hA0 | 8'(k));
            @(negedge wr_clk);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = 8'hA0 | 8'(k);
            req1_data  = 8'hB0 | 8'(k);
            #1;
            total++;
            if ({req0_ready, req1_ready} !== {~g, g}) begin
                bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {~g, g});
            end
            @(posedge wr_clk); #1;
            total++;
            if ({ram_wr_en, grant_id, ram_wr_data, ram_wr_addr} !== {1'b1, g, d, 4'(k)}) begin
                bad++; $display("FAIL rr_xfer k=%0d en=%b gnt=%b data=%h addr=%0d exp 1/%b/%h/%0d",
                                k, ram_wr_en, grant_id, ram_wr_data, ram_wr_addr, g, d, k);
            end
        end
        @(negedge wr_clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (wr_level !== 5'd8) begin
            bad++; $display("FAIL rr_level got=%0d exp=8", wr_level);
        end
    endtask

    task automatic test_wrap_reader();
        logic [4:0] rd_bin;
        logic [4:0] prev_gray;
        int         sent;
        int         reads;
        int         cyc;
        logic       wrap_seen;
        do_reset();
        exp_q.delete();
        rd_bin    = 5'd0;
        prev_gray = 5'd0;
        sent      = 0;
        reads     = 0;
        cyc       = 0;
        wrap_seen = 1'b0;
        while (reads < 40 && cyc < 400) begin
            @(negedge wr_clk);
            cyc++;
            if (wr_ptr_gray !== prev_gray) begin
                total++;
                if ($countones(wr_ptr_gray ^ prev_gray) != 1) begin
                    bad++; $display("FAIL wrap_gray_step prev=%b cur=%b exp one bit", prev_gray, wr_ptr_gray);
                end
                if (prev_gray == 5'b10000 && wr_ptr_gray == 5'd0) wrap_seen = 1'b1;
                prev_gray = wr_ptr_gray;
            end
            if (full) begin
                total++;
                if (wr_level !== 5'd16) begin
                    bad++; $display("FAIL wrap_full_level lvl=%0d exp=16", wr_level);
                end
            end
            if ((cyc % 3 == 0) && rd_bin != g2b(wr_ptr_gray)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL wrap_read_extra addr=%0d got=%h exp=none", rd_bin[3:0], mem[rd_bin[3:0]]);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (mem[rd_bin[3:0]] !== e) begin
                        bad++; $display("FAIL wrap_read_data n=%0d got=%h exp=%h", reads, mem[rd_bin[3:0]], e);
                    end
                end
                reads++;
                rd_bin      = rd_bin + 5'd1;
                rd_ptr_gray = rd_bin ^ (rd_bin >> 1);
            end
            req0_valid = (sent < 40);
            req0_data  = 8'h40 + 8'(sent);
            #1;
            if (req0_valid && req0_ready) begin
                exp_q.push_back(req0_data);
                sent++;
            end
        end
        req0_valid = 1'b0;
        total++;
        if (reads != 40) begin
            bad++; $display("FAIL wrap_read_count got=%0d exp=40 (cycle budget)", reads);
        end
        total++;
        if (!wrap_seen) begin
            bad++; $display("FAIL wrap_gray_wrap got=0 exp=1");
        end
        total++;
        if (wr_ptr_gray !== 5'b01100) begin
            bad++; $display("FAIL wrap_final_gray got=%b exp=01100", wr_ptr_gray);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        @(negedge wr_clk);
        req0_valid = 1'b1;
        req0_data  = 8'h77;
        @(posedge wr_clk); #1;
        total++;
        if (ram_wr_en !== 1'b1) begin
            bad++; $display("FAIL rif_pre_en got=%b exp=1", ram_wr_en);
        end
        #1;
        wr_rst_n = 1'b0;
        #1;
        total++;
        if ({ram_wr_en, req0_ready} !== 2'b00) begin
            bad++; $display("FAIL rif_drop en=%b ready=%b exp 0/0", ram_wr_en, req0_ready);
        end
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, wr_ptr_gray} !== 6'd0) begin
            bad++; $display("FAIL rif_no_commit en=%b gray=%b exp 0/0", ram_wr_en, wr_ptr_gray);
        end
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        #1;
        total++;
        if ({wr_ptr_gray, wr_level, ram_wr_addr} !== '0) begin
            bad++; $display("FAIL rif_ptrs gray=%b lvl=%0d addr=%0d exp 0", wr_ptr_gray, wr_level, ram_wr_addr);
        end
        @(posedge wr_clk); #1;
        total++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, wr_level} !== {1'b1, 4'd0, 8'h77, 5'd1}) begin
            bad++; $display("FAIL rif_restart en=%b addr=%0d data=%h lvl=%0d exp 1/0/77/1",
                            ram_wr_en, ram_wr_addr, ram_wr_data, wr_level);
        end
        @(negedge wr_clk);
        req0_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_release();
        test_round_robin();
        test_wrap_reader();
        test_reset_in_flight();
        repeat (2) @(negedge wr_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Write-side controller for the team's async FIFO built on the dual-port async RAM.
- Arbitrates between two write requesters with round-robin fairness and drives the RAM write port (enable/address/data) through one register stage.
- Maintains the binary and Gray write pointers and synchronises the read-domain Gray pointer into wr_clk.
- Generates full, almost_full and a write-side occupancy count.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 4, RAM address width; FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AF_MARGIN, 2, almost_full asserts when free slots are at or below this value (1 to 2^ADDR_WIDTH-1).

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rst_n  input  1  reset, asynchronous, active-low; clock wr_clk.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  DATA_WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  DATA_WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid.
- rd_ptr_gray  input  ADDR_WIDTH+1  read pointer, Gray-coded, from the rd_clk domain.
- ram_wr_en  output  1  RAM write enable, registered.
- ram_wr_addr  output  ADDR_WIDTH  RAM write address, registered.
- ram_wr_data  output  DATA_WIDTH  RAM write data, registered.
- wr_ptr_gray  output  ADDR_WIDTH+1  committed write pointer, Gray, to the read domain.
- full  output  1  FIFO full, registered.
- almost_full  output  1  free slots <= AF_MARGIN, registered.
- wr_level  output  ADDR_WIDTH+1  write-side occupancy, 0 to 2^ADDR_WIDTH, registered.
- grant_id  output  1  requester accepted in the last transfer cycle, registered.

Behaviour:
- Reset (wr_rst_n low, asynchronous):
  - All outputs go to 0: ram_wr_en, ram_wr_addr, ram_wr_data, wr_ptr_gray, full, almost_full, wr_level, grant_id.
  - The internal binary pointer, both synchroniser stages and the round-robin state also clear.
  - req*_ready is forced to 0 while reset is asserted.
  - A transfer in flight at reset assertion is dropped; ram_wr_en never pulses after reset asserts.
- Arbitration (combinational, single cycle):
  - Only one requester valid and full=0: that requester gets ready=1.
  - Both valid and full=0: the requester not served in the last transfer gets ready=1; the other gets 0.
  - After reset, requester 0 has priority.
  - full=1: both readies are 0.
  - ready never depends on the requester's own valid except through this arbitration.
- Transfer at edge N, when reqX_valid & reqX_ready:
  - The internal binary pointer increments at edge N.
  - grant_id is set to X and the round-robin state is updated.
  - ram_wr_en=1, ram_wr_addr=old pointer[ADDR_WIDTH-1:0], ram_wr_data=reqX_data, all valid during cycle N+1.
  - The RAM writes at edge N+1.
- No transfer: ram_wr_en=0 in the next cycle; ram_wr_addr and ram_wr_data hold their last values.
- Throughput: one word per cycle sustained, with back-to-back transfers from either requester.
- wr_ptr_gray:
  - Equals bin2gray of the pointer value committed to the RAM.
  - Updates at the same edge the RAM write occurs (N+1), so the read domain never sees a pointer ahead of written data.
  - Exactly one bit changes per update.
- Synchroniser: rd_ptr_gray passes through two wr_clk flops (rq_sync) before any use. There is no combinational path from rd_ptr_gray.
- full:
  - Registered each edge as (next Gray of the internal pointer) == {~rq_sync[top two bits], rq_sync[remaining bits]}.
  - Asserts on the edge of the transfer that fills the last slot.
  - Deasserts no earlier than 2 cycles after rd_ptr_gray advances (pessimistic; never optimistic).
- wr_level:
  - Registered as (next internal binary pointer − gray2bin(rq_sync)), modulo 2^(ADDR_WIDTH+1).
  - Counts from the arbitration pointer, so it leads wr_ptr_gray by one cycle.
- almost_full: registered as (2^ADDR_WIDTH − next level) <= AF_MARGIN.
- Pointer wrap:
  - The binary pointer wraps from 2^(ADDR_WIDTH+1)−1 to 0.
  - The address wraps at 2^ADDR_WIDTH.
  - full and level stay correct across the wrap.
- Simultaneous events:
  - Transfer and read-pointer advance in the same cycle: level reflects both once the synchroniser catches up.
  - full is never asserted with level < depth once settled.

Test Plan:
- Reset with both valid=1 -> both ready=0 while in reset, all outputs 0; after release, req0 accepted first.
- ADDR_WIDTH=4, rd_ptr_gray held 0, req0 streams 16 words 0x00..0x0F -> ram_wr_addr 0..15 with matching data, each one cycle after acceptance. Then full=1 after the 16th, almost_full=1 from level 14, wr_level=16, and a 17th word is stalled (ready=0).
- Both requesters valid continuously, req0 data 0xA*, req1 data 0xB* -> grants alternate 0,1,0,1…; grant_id toggles; ram_wr_data alternates A/B.
- From full, rd_ptr_gray steps to gray(1) -> full deasserts 3 edges later; one more write is accepted to address 0; full reasserts.
- 40 words written while a reader model advances rd_ptr_gray -> wr_ptr_gray changes exactly one bit per update, wraps past 31 to 0, and all 40 words are read back in order.
- wr_rst_n asserted in the cycle after an acceptance -> ram_wr_en is 0 immediately and the pointers read 0 after release.
